pipelined_control_decoder: RTL and testbench
============================================

Name: pipelined_control_decoder

Overview:
Registered successor to the single-cycle instruction decoder. It decodes LEGv8 instructions in ID and drives a registered control bundle into the ID/EX pipeline register. It also detects load-use hazards (stall plus bubble), accepts branch flush, flags undefined opcodes, and keeps saturating stall and illegal-instruction counters for debug.

Parameters:
REG_ADDR_W, 5, register-specifier width; fields are instr[4:0], [9:5], [20:16] with REG_ADDR_W=5.
ZERO_REG, 31, register index never considered a hazard source (XZR).
ALUOP_W, 2, width of ex_alu_op.
CNT_W, 16, width of the saturating stall and illegal counters.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction in ID
instr_valid  in  1  instr is real (not a bubble)
flush  in  1  branch taken; kill the instruction entering EX
id_stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real decoded instruction
ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_uncond  out  1 each  registered controls
ex_alu_op  out  ALUOP_W  registered ALU op class: 0=add, 1=pass-B/CBZ, 2=R-type funct
ex_rd  out  REG_ADDR_W  instr[4:0] registered
ex_illegal  out  1  one-cycle pulse: undefined opcode decoded
stall_cnt  out  CNT_W  cycles id_stall was high, saturating
illegal_cnt  out  CNT_W  illegal decodes, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs = 0, ex_valid = 0, both counters = 0. Takes effect mid-operation immediately. Release is synchronous to the next clk edge.
- Decode table (reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, uncond, alu_op):
  - LDUR [31:21]=11111000010: 0,1,1,1,1,0,0,0,0
  - STUR 11111000000: 1,1,0,0,0,1,0,0,0
  - AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000: 0,0,0,1,0,0,0,0,2
  - ADDI [31:22]=1001000100, SUBI 1101000100: 0,1,0,1,0,0,0,0,2
  - CBZ [31:24]=10110100: 1,0,0,0,0,0,1,0,1
  - B [31:26]=000101: 0,0,0,0,0,0,1,1,1
  - Match priority: B, CBZ, I-type, then 11-bit opcodes.
- Source registers read by ID:
  - R-type: Rn, Rm
  - LDUR, ADDI, SUBI: Rn
  - STUR: Rn, Rt
  - CBZ: Rt
  - B: none
- Hazard: hz = instr_valid & ex_valid & ex_memread & ex_rd != ZERO_REG & ex_rd equals any source register read.
- id_stall = hz & !flush (combinational, same cycle).
- Next-edge update of the EX register, in priority order:
  1. flush = 1: bubble (ex_valid=0, all controls 0, ex_illegal=0).
  2. id_stall = 1: bubble. ID instruction is held upstream and re-presented next cycle, when ex holds the bubble, so it is accepted (latency 1 extra cycle).
  3. instr_valid = 0: bubble.
  4. Undefined opcode: bubble; ex_illegal=1 for that cycle only; illegal_cnt+1.
  5. Otherwise: ex_valid=1, controls per table, ex_rd = instr[4:0].
- Normal latency: instr to ex_* = 1 clock.
- Counters: increment by 1 per qualifying edge and saturate at 2^CNT_W−1 with no wrap. stall_cnt counts edges where id_stall was 1. Illegal decodes suppressed by flush are not counted.
- Load to XZR never stalls.
- Back-to-back loads to the same register stall once per dependent consumer.

Test Plan:
- Reset mid-stream: drive ADD, pull rst_n low between edges -> ex_valid and all ex_* go to 0 immediately; both counters = 0.
- Decode sweep: 0xF8400041 (LDUR X1,[X2]) -> ex_memread=1, memtoreg=1, alusrc=1, regwrite=1, alu_op=0, ex_rd=1. 0x8B040023 (ADD X3,X1,X4) alone -> regwrite=1, alu_op=2, ex_rd=3. 0x14000004 (B) -> branch=1, uncond=1.
- Load-use: 0xF8400041 then 0x8B040023 -> id_stall=1 for exactly 1 cycle; ex_valid=0 for one cycle; ADD in EX one cycle later; stall_cnt=1.
- CBZ dependence: LDUR X1 then 0xB4000041 (CBZ X1) -> one stall. Same sequence with LDUR to X31 -> no stall.
- Flush over stall: hazard cycle with flush=1 -> id_stall=0, next ex_valid=0, stall_cnt unchanged.
- Illegal: 0x00000000 valid -> ex_illegal pulses 1 cycle, ex_valid=0, illegal_cnt=1. With CNT_W=2, five illegals -> illegal_cnt holds at 3.

Source files
------------

// File: rtl/pipelined_control_decoder.sv
// Registered LEGv8 control decoder for the ID stage.
// It decodes the instruction in ID and registers the control bundle into ID/EX.
// It also detects load-use hazards, applies branch flush, flags undefined
// opcodes, and keeps saturating debug counters.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr             instruction in ID
//   instr_valid       instr is a real instruction, not a bubble
//   flush             branch taken; the instruction entering EX is killed
//   id_stall          combinational; hold PC and IF/ID this cycle
//   ex_valid          EX holds a real decoded instruction
//   ex_reg2loc ... ex_uncond, ex_alu_op, ex_rd   registered control bundle
//   ex_illegal        one-cycle pulse when an undefined opcode is decoded
//   stall_cnt         saturating count of stalled cycles
//   illegal_cnt       saturating count of illegal decodes
module pipelined_control_decoder #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ZERO_REG   = 31,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic                  ex_reg2loc,
  output logic                  ex_alusrc,
  output logic                  ex_memtoreg,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_branch,
  output logic                  ex_uncond,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_illegal,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      illegal_cnt
);

  typedef struct packed {
    logic               reg2loc;
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               uncond;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] AluPassB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(2);

  logic [REG_ADDR_W-1:0] rt, rn, rm;
  assign rt = instr[REG_ADDR_W-1:0];
  assign rn = instr[5 +: REG_ADDR_W];
  assign rm = instr[16 +: REG_ADDR_W];

  // Shift-amount/immediate bits are not needed for control decode.
  logic unused_instr;
  assign unused_instr = ^instr;

  ctrl_t dec_ctrl;
  logic  dec_legal;
  logic  uses_rn, uses_rm, uses_rt;

  // Priority: B, CBZ, I-type, then 11-bit opcodes.
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    uses_rn   = 1'b0;
    uses_rm   = 1'b0;
    uses_rt   = 1'b0;
    if (instr[31:26] == 6'b000101) begin
      dec_ctrl.branch = 1'b1;
      dec_ctrl.uncond = 1'b1;
      dec_ctrl.alu_op = AluPassB;
    end else if (instr[31:24] == 8'b10110100) begin
      dec_ctrl.reg2loc = 1'b1;
      dec_ctrl.branch  = 1'b1;
      dec_ctrl.alu_op  = AluPassB;
      uses_rt          = 1'b1;
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      dec_ctrl.alusrc   = 1'b1;
      dec_ctrl.regwrite = 1'b1;
      dec_ctrl.alu_op   = AluFunct;
      uses_rn           = 1'b1;
    end else begin
      case (instr[31:21])
        11'b11111000010: begin // LDUR
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.memtoreg = 1'b1;
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.memread  = 1'b1;
          uses_rn           = 1'b1;
        end
        11'b11111000000: begin // STUR
          dec_ctrl.reg2loc  = 1'b1;
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.memwrite = 1'b1;
          uses_rn           = 1'b1;
          uses_rt           = 1'b1;
        end
        11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000: begin
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.alu_op   = AluFunct;
          uses_rn           = 1'b1;
          uses_rm           = 1'b1;
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_illegal_q, ex_illegal_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      illegal_cnt_q, illegal_cnt_d;

  // Load-use hazard against the load currently in EX; XZR is never a real dependency.
  logic src_match, hazard;
  assign src_match = (uses_rn && rn == ex_rd_q) || (uses_rm && rm == ex_rd_q) ||
                     (uses_rt && rt == ex_rd_q);
  assign hazard    = instr_valid && ex_valid_q && ex_ctrl_q.memread &&
                     (ex_rd_q != REG_ADDR_W'(ZERO_REG)) && src_match;
  assign id_stall  = hazard && !flush;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = '0;
    ex_rd_d       = '0;
    ex_illegal_d  = 1'b0;
    illegal_cnt_d = illegal_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (id_stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!flush && !id_stall && instr_valid) begin
      if (!dec_legal) begin
        ex_illegal_d = 1'b1;
        if (illegal_cnt_q != '1) begin
          illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
      end else begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = dec_ctrl;
        ex_rd_d    = rt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_rd_q       <= '0;
      ex_illegal_q  <= 1'b0;
      stall_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      ex_illegal_q  <= ex_illegal_d;
      stall_cnt_q   <= stall_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_reg2loc  = ex_ctrl_q.reg2loc;
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_memtoreg = ex_ctrl_q.memtoreg;
  assign ex_regwrite = ex_ctrl_q.regwrite;
  assign ex_memread  = ex_ctrl_q.memread;
  assign ex_memwrite = ex_ctrl_q.memwrite;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_uncond   = ex_ctrl_q.uncond;
  assign ex_alu_op   = ex_ctrl_q.alu_op;
  assign ex_rd       = ex_rd_q;
  assign ex_illegal  = ex_illegal_q;
  assign stall_cnt   = stall_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipelined_control_decoder.sv
// Scoreboard bench: the driver predicts each cycle's visible outputs from a
// mnemonic-level model and queues them; a monitor pops and compares on negedge.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_pipelined_control_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  logic       id_stall, ex_valid, ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite;
  logic       ex_memread, ex_memwrite, ex_branch, ex_uncond, ex_illegal;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rd;
  logic [15:0] stall_cnt, illegal_cnt;

  logic       b_stall, b_valid, b_reg2loc, b_alusrc, b_memtoreg, b_regwrite;
  logic       b_memread, b_memwrite, b_branch, b_uncond, b_illegal;
  logic [1:0] b_alu_op;
  logic [4:0] b_rd;
  logic [1:0] b_stall_cnt, b_illegal_cnt;

  pipelined_control_decoder dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_reg2loc(ex_reg2loc),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_uncond(ex_uncond), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
    .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
  );

  pipelined_control_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .id_stall(b_stall), .ex_valid(b_valid), .ex_reg2loc(b_reg2loc),
    .ex_alusrc(b_alusrc), .ex_memtoreg(b_memtoreg), .ex_regwrite(b_regwrite),
    .ex_memread(b_memread), .ex_memwrite(b_memwrite), .ex_branch(b_branch),
    .ex_uncond(b_uncond), .ex_alu_op(b_alu_op), .ex_rd(b_rd), .ex_illegal(b_illegal),
    .stall_cnt(b_stall_cnt), .illegal_cnt(b_illegal_cnt)
  );

  logic [16:0] act_bundle, act_bundle2;
  assign act_bundle  = {ex_valid, ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                        ex_memwrite, ex_branch, ex_uncond, ex_alu_op, ex_rd, ex_illegal};
  assign act_bundle2 = {b_valid, b_reg2loc, b_alusrc, b_memtoreg, b_regwrite, b_memread,
                        b_memwrite, b_branch, b_uncond, b_alu_op, b_rd, b_illegal};

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int KLdur = 0, KStur = 1, KR = 2, KI = 3, KCbz = 4, KB = 5, KIll = 6;

  function automatic int classify(input logic [31:0] i);
    if (i[31:26] == 6'b000101) return KB;
    if (i[31:24] == 8'hB4) return KCbz;
    if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100) return KI;
    case (i[31:21])
      11'b11111000010: return KLdur;
      11'b11111000000: return KStur;
      11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000: return KR;
      default: return KIll;
    endcase
  endfunction

  // reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, uncond, alu_op
  function automatic logic [9:0] ctrl_of(input int k);
    case (k)
      KLdur:   return {8'b0_1_1_1_1_0_0_0, 2'd0};
      KStur:   return {8'b1_1_0_0_0_1_0_0, 2'd0};
      KR:      return {8'b0_0_0_1_0_0_0_0, 2'd2};
      KI:      return {8'b0_1_0_1_0_0_0_0, 2'd2};
      KCbz:    return {8'b1_0_0_0_0_0_1_0, 2'd1};
      KB:      return {8'b0_0_0_0_0_0_1_1, 2'd1};
      default: return 10'd0;
    endcase
  endfunction

  function automatic bit reads(input int k, input logic [31:0] i, input logic [4:0] r);
    case (k)
      KR:             return r == i[9:5] || r == i[20:16];
      KLdur, KI:      return r == i[9:5];
      KStur:          return r == i[9:5] || r == i[4:0];
      KCbz:           return r == i[4:0];
      default:        return 1'b0;
    endcase
  endfunction

  // Model EX contents at instruction level.
  bit         m_valid = 0;
  int         m_kind = KIll;
  logic [4:0] m_rd = '0;
  bit         m_ill = 0;
  int         m_stalls = 0;
  int         m_illegals = 0;

  typedef struct {
    logic        stall;
    logic [16:0] bundle;
    int          stalls;
    int          illegals;
  } exp_t;
  exp_t sb[$];

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Called at posedge+1: apply inputs, queue this cycle's expectation, advance model.
  task automatic issue(input logic [31:0] i, input bit v, input bit f, output bit stalled);
    int   k;
    exp_t e;
    instr       = i;
    instr_valid = v;
    flush       = f;
    k = classify(i);
    stalled = v && m_valid && m_kind == KLdur && m_rd != 5'd31 && reads(k, i, m_rd) && !f;
    e.stall    = stalled;
    e.bundle   = m_valid ? {1'b1, ctrl_of(m_kind), m_rd, 1'b0} : {16'd0, m_ill};
    e.stalls   = m_stalls;
    e.illegals = m_illegals;
    sb.push_back(e);
    if (stalled) m_stalls++;
    m_valid = 0;
    m_ill   = 0;
    m_rd    = '0;
    if (!f && !stalled && v) begin
      if (k == KIll) begin
        m_ill = 1;
        m_illegals++;
      end else begin
        m_valid = 1;
        m_kind  = k;
        m_rd    = i[4:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Upstream behaviour: a stalled instruction is re-presented next cycle.
  task automatic send(input logic [31:0] i, input bit v, input bit f);
    bit st;
    int n = 0;
    do begin
      issue(i, v, f, st);
      n++;
    end while (st && n < 4);
    if (st) begin
      n_checks++;
      n_err++;
      $display("FAIL stall_bound: got stall after %0d tries expected release", n);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("id_stall", {31'd0, id_stall}, {31'd0, e.stall});
        chk("id_stall_w2", {31'd0, b_stall}, {31'd0, e.stall});
        chk("ex_bundle", {15'd0, act_bundle}, {15'd0, e.bundle});
        chk("ex_bundle_w2", {15'd0, act_bundle2}, {15'd0, e.bundle});
        chk("stall_cnt", {16'd0, stall_cnt}, sat(e.stalls, 65535));
        chk("illegal_cnt", {16'd0, illegal_cnt}, sat(e.illegals, 65535));
        chk("stall_cnt_w2", {30'd0, b_stall_cnt}, sat(e.stalls, 3));
        chk("illegal_cnt_w2", {30'd0, b_illegal_cnt}, sat(e.illegals, 3));
      end
    end
  end

  // ---------------- random instruction builder ----------------
  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 4))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      3: return 5'd31;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [10:0] rops[4];
    rops[0] = 11'b10001010000;
    rops[1] = 11'b10101010000;
    rops[2] = 11'b10001011000;
    rops[3] = 11'b11001011000;
    case ($urandom_range(0, 6))
      0: return {11'b11111000010, 9'($urandom), 2'b00, rreg(), rreg()};
      1: return {11'b11111000000, 9'($urandom), 2'b00, rreg(), rreg()};
      2: return {rops[$urandom_range(0, 3)], rreg(), 6'($urandom), rreg(), rreg()};
      3: return {($urandom_range(0, 1) == 0) ? 10'b1001000100 : 10'b1101000100,
                 12'($urandom), rreg(), rreg()};
      4: return {8'hB4, 19'($urandom), rreg()};
      5: return {6'b000101, 26'($urandom)};
      default: return ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Decode sweep and load-use
    send(32'hF8400041, 1, 0);   // LDUR X1,[X2]
    send(32'h8B040023, 1, 0);   // ADD X3,X1,X4: one stall
    send(32'h0, 0, 0);
    send(32'h8B040023, 1, 0);   // ADD alone
    send(32'h14000004, 1, 0);   // B
    // CBZ dependence, then with load to XZR
    send(32'hF8400041, 1, 0);
    send(32'hB4000041, 1, 0);   // CBZ X1: one stall
    send(32'hF840005F, 1, 0);   // LDUR X31
    send(32'hB400005F, 1, 0);   // CBZ X31: no stall
    // Flush over stall
    send(32'hF8400041, 1, 0);
    send(32'h8B040023, 1, 1);
    send(32'h0, 0, 0);
    // Back-to-back loads to the same register
    send(32'hF8400041, 1, 0);   // LDUR X1,[X2]
    send(32'hF8400021, 1, 0);   // LDUR X1,[X1]: stall
    send(32'h8B040023, 1, 0);   // ADD uses X1: stall
    // Illegal pulses, saturation of the 2-bit counter
    repeat (5) send(32'h0, 1, 0);
    send(32'h0, 1, 1);          // flushed illegal: not counted
    send(32'h0, 0, 0);
    // Random
    for (int n = 0; n < 1500; n++) begin
      send(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    // Asynchronous reset mid-stream
    instr_valid = 1'b0;
    flush       = 1'b0;
    @(posedge clk);
    #1;
    instr       = 32'h8B040023;
    instr_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_reset_ex_valid", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_bundle", {15'd0, act_bundle}, 32'd0);
    chk("reset_bundle_w2", {15'd0, act_bundle2}, 32'd0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_illegal_cnt", {16'd0, illegal_cnt}, 32'd0);
    chk("reset_cnt_w2", {28'd0, b_stall_cnt, b_illegal_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
